// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: reset vector, NOP word,
// FSM state encoding and small PC helpers.
package fetch_unit_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC = 32'hBFC0_0000;
  localparam word_t NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_e;

  // Sequential PC; wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched word and its PC, used when the
// word arrives while the pipeline cannot accept it.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  word_t word_in,
  input  word_t pc_in,
  output logic  valid,
  output word_t word,
  output word_t pc
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)        valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (clear) valid <= 1'b0;
  end

  // NOTE: the payload is not reset; it is only ever read while valid is set,
  // so omitting the reset keeps the data path a plain enable register.
  always_ff @(posedge clk) begin
    if (load) begin
      word <= word_in;
      pc   <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request FSM and IF/ID register.
// Define FETCH_DELAY_SLOT_EN to execute the word after a branch (delay slot).
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stallF,
  input  logic         stallD,
  input  logic         pcsrcD,
  input  word_t        pcbranchD,
  input  logic         jumpD,
  input  word_t        pcjumpD,
  input  logic         jrD,
  input  word_t        pcjrD,
  fetch_unit_if.master imem,
  output word_t        instrD,
  output word_t        pcD,
  output word_t        pcplus4D,
  output logic         validD,
  output logic         imem_stallF
);

  fetch_state_e state, state_next;
  word_t        pc, pc_next;

  logic  redirect;
  word_t target;
  logic  go;
  logic  squash;
  logic  steer_valid;
  word_t steer_target;

  logic  deliver;
  word_t deliver_word, deliver_pc;
  logic  req;

  logic  buf_load, buf_clear, buf_valid;
  word_t buf_word, buf_pc;

  assign redirect = !stallD && (jrD || jumpD || pcsrcD);
  assign target   = jrD ? pcjrD : (jumpD ? pcjumpD : pcbranchD);
  assign go       = !stallF && !stallD;

`ifdef FETCH_DELAY_SLOT_EN
  // The in-flight word is the delay slot: keep it and remember the target
  // until that word has been handed to decode.
  logic  pend_valid;
  word_t pend_target;

  assign squash       = 1'b0;
  assign steer_valid  = redirect || pend_valid;
  assign steer_target = redirect ? target : pend_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_target <= NOP;
    end else if (deliver) begin
      pend_valid  <= 1'b0;
    end else if (redirect && (state == FETCH || state == HOLD)) begin
      pend_valid  <= 1'b1;
      pend_target <= target;
    end
  end
`else
  assign squash       = redirect;
  assign steer_valid  = 1'b0;
  assign steer_target = target;
`endif

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block can leave a signal unassigned and infer a latch.
    state_next   = state;
    pc_next      = pc;
    deliver      = 1'b0;
    deliver_word = buf_word;
    deliver_pc   = buf_pc;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    req          = 1'b0;
    imem_stallF  = 1'b1;

    unique case (state)
      IDLE: begin
        // imem_ack is deliberately ignored: it may belong to a pre-reset request.
        state_next = FETCH;
        if (redirect) pc_next = target;
      end
      FETCH: begin
        req         = 1'b1;
        imem_stallF = !imem.imem_ack;
        if (imem.imem_ack) begin
          if (squash) begin
            pc_next = target;
          end else if (go) begin
            deliver      = 1'b1;
            deliver_word = imem.imem_rdata;
            deliver_pc   = pc;
          end else begin
            buf_load   = 1'b1;
            state_next = HOLD;
          end
        end else if (squash) begin
          pc_next    = target;
          state_next = DISCARD;
        end
      end
      HOLD: begin
        imem_stallF = 1'b0;
        if (squash) begin
          buf_clear  = 1'b1;
          pc_next    = target;
          state_next = FETCH;
        end else if (go) begin
          deliver    = buf_valid;
          buf_clear  = 1'b1;
          state_next = FETCH;
        end
      end
      DISCARD: begin
        if (imem.imem_ack) state_next = FETCH;
        if (redirect)      pc_next    = target;
      end
      default: state_next = IDLE;
    endcase

    if (deliver) pc_next = steer_valid ? steer_target : pc_plus4(deliver_pc);
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instrD   <= NOP;
      pcD      <= NOP;
      pcplus4D <= NOP;
      validD   <= 1'b0;
    end else if (!stallD) begin
      if (deliver) begin
        instrD   <= deliver_word;
        pcD      <= deliver_pc;
        pcplus4D <= pc_plus4(deliver_pc);
        validD   <= 1'b1;
      end else begin
        instrD   <= NOP;
        validD   <= 1'b0;
      end
    end
  end

  fetch_buffer u_buffer (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .clear   (buf_clear),
    .word_in (imem.imem_rdata),
    .pc_in   (pc),
    .valid   (buf_valid),
    .word    (buf_word),
    .pc      (buf_pc)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 stallF  in  1  from hazard unit; hold PC, issue no new fetch.
REQ-004 stallD  in  1  from hazard unit; hold IF/ID outputs.
REQ-005 pcsrcD  in  1  taken branch resolved in D; pcbranchD  in  32  its target.
REQ-006 jumpD  in  1  J/JAL in D; pcjumpD  in  32  its target.
REQ-007 jrD  in  1  JR/JALR in D; pcjrD  in  32  forwarded rs value.
REQ-008 imem_req  out  1  instruction-memory request; imem_addr  out  32  word address.
REQ-009 imem_ack  in  1  read data valid this cycle; imem_rdata  in  32  instruction word.
REQ-010 instrD  out  32; pcD  out  32; pcplus4D  out  32; validD  out  1  IF/ID register contents.
REQ-011 imem_stallF  out  1  no word available for D this cycle; hazard unit ORs into stallF/stallD.

Function
REQ-012 Redirect priority SHALL be jrD > jumpD > pcsrcD; redirect is honoured only in cycles with stallD=0.
REQ-013 FSM states SHALL be IDLE, FETCH, HOLD, DISCARD.
REQ-014 IDLE: imem_req=0; exit to FETCH after one cycle.
REQ-015 FETCH: imem_req=1, imem_addr=PC, both held stable until imem_ack; one outstanding request max.
REQ-016 FETCH, ack, stallF=0: instrD<=rdata, pcD<=PC, pcplus4D<=PC+4, validD<=1, PC<=next PC, stay FETCH (back-to-back, next request following cycle).
REQ-017 FETCH, ack, stallF=1: word and its PC captured in 1-entry buffer, go HOLD, imem_req=0.
REQ-018 HOLD: when stallF=0, buffer delivered to IF/ID per REQ-016, PC advanced, go FETCH.
REQ-019 FETCH, redirect without ack: PC<=target, go DISCARD; DISCARD drops next acked word then enters FETCH at target.
REQ-020 FETCH, redirect with ack same cycle: acked word dropped, PC<=target, stay FETCH.
REQ-021 HOLD, redirect: buffer invalidated, PC<=target, go FETCH.
REQ-022 When no word is delivered and stallD=0, IF/ID SHALL load bubble: instrD=0, validD=0, PCs unchanged.
REQ-023 stallD=1 SHALL hold all IF/ID outputs regardless of delivery; a delivered word then goes to buffer (HOLD).
REQ-024 imem_stallF=1 in IDLE, DISCARD, and FETCH without ack; 0 in HOLD and FETCH with ack.
REQ-025 PC+4 arithmetic SHALL be 32-bit modulo; 0xFFFFFFFC wraps to 0x00000000.

Reset
REQ-026 rst: PC=0xBFC00000, state=IDLE, buffer invalid, instrD=0, pcD=0, pcplus4D=0, validD=0, imem_req=0.
REQ-027 rst mid-request: outstanding ack after reset SHALL be ignored (IDLE does not sample imem_ack).

Configuration
REQ-028 Macro FETCH_DELAY_SLOT_EN defined: instruction at branch+4 executes; redirect is stored in a pending-target register and applied after the delay-slot word is delivered (no drop in REQ-019/020/021; word kept).
REQ-029 Macro undefined: redirect squashes per REQ-019..021; IF/ID loads bubble in redirect cycle.

Structure
REQ-030 Shared package SHALL hold RESET_PC constant, NOP encoding (32'h0) and FSM state enum.
REQ-031 One sub-module fetch_buffer (1-entry word+PC holding register with valid) is natural; PC/FSM stay in fetch_unit.

Verification
REQ-032 Reset, then ack every cycle: imem_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 consecutive; validD=1 from cycle 3.
REQ-033 ack delayed 3 cycles: imem_addr stable 0xBFC00000 all 3 cycles; imem_stallF=1 for 2 cycles; instrD=rdata after ack.
REQ-034 ack with stallF=1 for 2 cycles: imem_req=0 in HOLD, instrD unchanged; word appears cycle after stallF drops.
REQ-035 Macro off, pcsrcD=1 pcbranchD=0x00000100 while request outstanding: returning word dropped, next imem_addr 0x00000100, validD=0 one cycle.
REQ-036 Macro on, same stimulus: returning word delivered (validD=1), then imem_addr 0x00000100.
REQ-037 jrD, jumpD, pcsrcD all 1 with targets 0x10/0x20/0x30: next fetch at 0x10.
